// File: rtl/jam_pkg.sv
// rtl/jam_pkg.sv - shared types and constants for the data RAM and its DMA engine
package jam_pkg;

    // Address/data widths shared by the data RAM and every initiator on its port.
    localparam int JAM_AW = 8;
    localparam int JAM_DW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } dma_state_t;

    localparam logic DMA_MODE_COPY = 1'b0;
    localparam logic DMA_MODE_FILL = 1'b1;

endpackage

// File: rtl/dmem_dma_engine_if.sv
// rtl/dmem_dma_engine_if.sv - single-port data RAM bus (initiator = master, RAM = slave)
//
// Signals:
//   mem_addr     RAM byte address
//   mem_wr_data  write data
//   mem_write    write enable
//   mem_read     read enable
//   mem_rd_data  read data, combinational from mem_addr
interface dmem_dma_engine_if #(
    parameter int AW = jam_pkg::JAM_AW,
    parameter int DW = jam_pkg::JAM_DW
) ();

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data;
    logic          mem_write;
    logic          mem_read;
    logic [DW-1:0] mem_rd_data;

    modport master (
        output mem_addr,
        output mem_wr_data,
        output mem_write,
        output mem_read,
        input  mem_rd_data
    );

    modport slave (
        input  mem_addr,
        input  mem_wr_data,
        input  mem_write,
        input  mem_read,
        output mem_rd_data
    );

endinterface

// File: rtl/dmem_dma_engine_ram.sv
// rtl/dmem_dma_engine_ram.sv - 2^AW-byte data RAM, single port plus a load port
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset clears every byte
//   bus                 slave side of the data RAM port (combinational read)
//   ld_en/ld_addr/ld_data
//                       byte load port for initialising contents while the
//                       port initiator is idle; a bus write wins on collision
module dmem_dma_engine_ram
    import jam_pkg::*;
#(
    parameter int AW = JAM_AW,
    parameter int DW = JAM_DW
) (
    input  logic                  clk,
    input  logic                  rst,
    dmem_dma_engine_if.slave      bus,
    input  logic                  ld_en,
    input  logic [AW-1:0]         ld_addr,
    input  logic [DW-1:0]         ld_data
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (bus.mem_write) begin
            mem_d[bus.mem_addr] = bus.mem_wr_data;
        end else if (ld_en) begin
            mem_d[ld_addr] = ld_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign bus.mem_rd_data = mem_q[bus.mem_addr];

endmodule

// File: rtl/dmem_dma_engine.sv
// rtl/dmem_dma_engine.sv - byte-serial block copy/fill initiator for the data RAM
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset aborts any transfer
//   start        one-cycle request, only looked at in IDLE
//   mode         0 = copy src->dst, 1 = fill dst with fill_val
//   src, dst     start addresses (src unused for fill)
//   len          byte count, 0 completes immediately with no RAM access
//   fill_val     fill byte
//   busy         high in every state except IDLE
//   done         one-cycle completion pulse
//   bus          master side of the data RAM port, owned while busy
module dmem_dma_engine
    import jam_pkg::*;
#(
    parameter int AW = JAM_AW,
    parameter int DW = JAM_DW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [AW-1:0]         src,
    input  logic [AW-1:0]         dst,
    input  logic [AW-1:0]         len,
    input  logic [DW-1:0]         fill_val,
    output logic                  busy,
    output logic                  done,
    dmem_dma_engine_if.master     bus
);

    dma_state_t    state_q, state_d;
    logic [AW-1:0] src_q,   src_d;
    logic [AW-1:0] dst_q,   dst_d;
    logic [AW-1:0] cnt_q,   cnt_d;
    logic          mode_q,  mode_d;
    logic [DW-1:0] fill_q,  fill_d;
    logic [DW-1:0] data_q,  data_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= DMA_MODE_COPY;
            fill_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            fill_q  <= fill_d;
            data_q  <= data_d;
        end
    end

    // Next state. Addresses simply wrap modulo 2^AW; overlapping copies are
    // deliberately ascending, so a dst just above src re-reads written bytes.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        fill_d  = fill_q;
        data_d  = data_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    src_d  = src;
                    dst_d  = dst;
                    cnt_d  = len;
                    mode_d = mode;
                    fill_d = fill_val;
                    if (len == '0) begin
                        state_d = DONE;
                    end else if (mode == DMA_MODE_FILL) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                data_d  = bus.mem_rd_data;
                src_d   = src_q + AW'(1);
                state_d = WRITE;
            end
            WRITE: begin
                dst_d = dst_q + AW'(1);
                cnt_d = cnt_q - AW'(1);
                if (cnt_q == AW'(1)) begin
                    state_d = DONE;
                end else if (mode_q == DMA_MODE_COPY) begin
                    state_d = READ;
                end else begin
                    state_d = WRITE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs depend only on registered state, so an asynchronous reset
    // clears them immediately and no input reaches an output combinationally.
    always_comb begin
        busy            = (state_q != IDLE);
        done            = (state_q == DONE);
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wr_data = '0;

        case (state_q)
            READ: begin
                bus.mem_read = 1'b1;
                bus.mem_addr = src_q;
            end
            WRITE: begin
                bus.mem_write   = 1'b1;
                bus.mem_addr    = dst_q;
                bus.mem_wr_data = (mode_q == DMA_MODE_FILL) ? fill_q : data_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_dma_engine.sv
// tb/tb_dmem_dma_engine.sv - self-checking bench for dmem_dma_engine with the data RAM
module tb_dmem_dma_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mode;
    logic [7:0] src;
    logic [7:0] dst;
    logic [7:0] len;
    logic [7:0] fill_val;
    logic       busy;
    logic       done;
    logic       ld_en;
    logic [7:0] ld_addr;
    logic [7:0] ld_data;

    dmem_dma_engine_if #(.AW(8), .DW(8)) bus ();

    dmem_dma_engine #(.AW(8), .DW(8)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .src      (src),
        .dst      (dst),
        .len      (len),
        .fill_val (fill_val),
        .busy     (busy),
        .done     (done),
        .bus      (bus.master)
    );

    dmem_dma_engine_ram #(.AW(8), .DW(8)) u_ram (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data)
    );

    always #5 clk = ~clk;

    logic [7:0] ref_mem [256];
    int n_chk  = 0;
    int n_pass = 0;

    int r_done_cyc, r_done_cnt, r_busy_cnt, r_busy_after;
    int r_wr, r_rd, r_both, r_idle_bad, r_wr_addr_bad, r_timeout;

    typedef struct {
        logic        m;
        logic [7:0]  s;
        logic [7:0]  d;
        logic [7:0]  n;
        logic [7:0]  f;
        logic [7:0]  pa;
        int          pn;
        logic [31:0] pv;
        logic [7:0]  ea;
        int          en;
        logic [31:0] ev;
        int          edone;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_en   = 1'b0;
        ref_mem[a] = d;
    endtask

    // Reference: ascending byte-serial copy or fill, addresses modulo 256.
    task automatic model(input logic m, input logic [7:0] s, input logic [7:0] d,
                         input logic [7:0] n, input logic [7:0] f);
        logic [7:0] sa;
        logic [7:0] da;
        sa = s;
        da = d;
        for (int i = 0; i < int'(n); i++) begin
            ref_mem[da] = m ? f : ref_mem[sa];
            sa = sa + 8'd1;
            da = da + 8'd1;
        end
    endtask

    task automatic run_xfer(input logic m, input logic [7:0] s, input logic [7:0] d,
                            input logic [7:0] n, input logic [7:0] f, input int inj_cyc);
        logic [7:0] exp_wa;
        bit finished;
        r_done_cyc = 0; r_done_cnt = 0; r_busy_cnt = 0; r_busy_after = 1;
        r_wr = 0; r_rd = 0; r_both = 0; r_idle_bad = 0; r_wr_addr_bad = 0; r_timeout = 0;
        exp_wa   = d;
        finished = 1'b0;
        @(negedge clk);
        start = 1'b1; mode = m; src = s; dst = d; len = n; fill_val = f;
        for (int cyc = 1; cyc <= 600; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                start    = 1'b0;
                src      = 8'($urandom);
                dst      = 8'($urandom);
                len      = 8'($urandom);
                fill_val = 8'($urandom);
                mode     = 1'($urandom);
            end
            if (busy) r_busy_cnt++;
            if (done) begin
                r_done_cnt++;
                if (r_done_cnt == 1) r_done_cyc = cyc;
            end
            if (bus.mem_read && bus.mem_write) r_both++;
            if (bus.mem_read) r_rd++;
            if (bus.mem_write) begin
                r_wr++;
                if (bus.mem_addr != exp_wa) r_wr_addr_bad++;
                exp_wa = exp_wa + 8'd1;
            end
            if (!bus.mem_read && !bus.mem_write &&
                (bus.mem_addr != 8'd0 || bus.mem_wr_data != 8'd0)) r_idle_bad++;
            if (r_done_cnt > 0 && cyc == r_done_cyc + 1) begin
                r_busy_after = int'(busy);
                finished = 1'b1;
                break;
            end
            if (cyc == inj_cyc) begin
                start = 1'b1; mode = ~m; dst = 8'hC0; len = 8'd2; fill_val = 8'hEE;
            end
            if (cyc == inj_cyc + 1) start = 1'b0;
        end
        start = 1'b0;
        if (!finished) r_timeout = 1;
    endtask

    task automatic check_xfer(input string name, input logic m, input logic [7:0] s,
                              input logic [7:0] d, input logic [7:0] n,
                              input logic [7:0] f, input int inj_cyc);
        int exp_done;
        int mism;
        run_xfer(m, s, d, n, f, inj_cyc);
        model(m, s, d, n, f);
        exp_done = (n == 8'd0) ? 1 : (m ? int'(n) + 1 : 2 * int'(n) + 1);
        chk({name, "_timeout"},  r_timeout, 0);
        chk({name, "_done_cyc"}, r_done_cyc, exp_done);
        chk({name, "_done_cnt"}, r_done_cnt, 1);
        chk({name, "_busy_cyc"}, r_busy_cnt, exp_done);
        chk({name, "_busy_after"}, r_busy_after, 0);
        chk({name, "_writes"},   r_wr, int'(n));
        chk({name, "_reads"},    r_rd, m ? 0 : int'(n));
        chk({name, "_rd_and_wr"}, r_both, 0);
        chk({name, "_idle_bus"}, r_idle_bad, 0);
        chk({name, "_wr_addr"},  r_wr_addr_bad, 0);
        mism = 0;
        for (int i = 0; i < 256; i++) begin
            if (u_ram.mem_q[i] != ref_mem[i]) mism++;
        end
        chk({name, "_mem_model"}, mism, 0);
    endtask

    initial begin
        logic [7:0] a;
        int         mism;

        vt[0] = '{m:1'b0, s:8'h10, d:8'h80, n:8'd4, f:8'h00, pa:8'h10, pn:4,
                  pv:32'h44332211, ea:8'h80, en:4, ev:32'h44332211, edone:9};
        vt[1] = '{m:1'b1, s:8'h00, d:8'hF0, n:8'd3, f:8'h5A, pa:8'h00, pn:0,
                  pv:32'h0, ea:8'hF0, en:3, ev:32'h005A5A5A, edone:4};
        vt[2] = '{m:1'b0, s:8'hFE, d:8'h40, n:8'd4, f:8'h00, pa:8'hFE, pn:4,
                  pv:32'h0D0C0B0A, ea:8'h40, en:4, ev:32'h0D0C0B0A, edone:9};
        vt[3] = '{m:1'b1, s:8'h00, d:8'hFF, n:8'd2, f:8'hA5, pa:8'h00, pn:0,
                  pv:32'h0, ea:8'hFF, en:2, ev:32'h0000A5A5, edone:3};
        vt[4] = '{m:1'b0, s:8'h10, d:8'h11, n:8'd4, f:8'h00, pa:8'h10, pn:1,
                  pv:32'h000000AA, ea:8'h11, en:4, ev:32'hAAAAAAAA, edone:9};
        vt[5] = '{m:1'b0, s:8'h30, d:8'h31, n:8'd0, f:8'h00, pa:8'h00, pn:0,
                  pv:32'h0, ea:8'h31, en:0, ev:32'h0, edone:1};

        rst = 1'b1; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0;
        fill_val = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

        repeat (2) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_bus", int'({bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wr_data}), 0);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            a = vt[v].pa;
            for (int k = 0; k < vt[v].pn; k++) begin
                preload(a, vt[v].pv[8*k +: 8]);
                a = a + 8'd1;
            end
            check_xfer($sformatf("vec%0d", v), vt[v].m, vt[v].s, vt[v].d, vt[v].n, vt[v].f, 0);
            chk($sformatf("vec%0d_done_table", v), r_done_cyc, vt[v].edone);
            a = vt[v].ea;
            for (int k = 0; k < vt[v].en; k++) begin
                chk($sformatf("vec%0d_byte%0d", v, k), int'(u_ram.mem_q[a]), int'(vt[v].ev[8*k +: 8]));
                a = a + 8'd1;
            end
        end

        // Second start in the middle of a copy must be dropped.
        chk("pre_busy_c0", int'(u_ram.mem_q[8'hC0]), 0);
        check_xfer("start_busy", 1'b0, 8'h10, 8'h90, 8'd4, 8'h00, 3);
        chk("start_busy_c0", int'(u_ram.mem_q[8'hC0]), 0);
        chk("start_busy_c1", int'(u_ram.mem_q[8'hC1]), 0);

        // Reset in the middle of a fill.
        @(negedge clk);
        start = 1'b1; mode = 1'b1; dst = 8'h20; len = 8'd8; fill_val = 8'h77;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("midop_busy_before", int'(busy), 1);
        #1 rst = 1'b1;
        #1;
        chk("midop_busy", int'(busy), 0);
        chk("midop_done", int'(done), 0);
        chk("midop_rw", int'({bus.mem_read, bus.mem_write}), 0);
        chk("midop_addr", int'(bus.mem_addr), 0);
        chk("midop_wdata", int'(bus.mem_wr_data), 0);
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        mism = 0;
        for (int i = 0; i < 256; i++) if (u_ram.mem_q[i] != 8'h00) mism++;
        chk("midop_ram_cleared", mism, 0);
        check_xfer("after_rst", 1'b1, 8'h00, 8'h20, 8'd8, 8'h77, 0);

        // Randomised transfers against the reference model.
        for (int t = 0; t < 24; t++) begin
            logic       rm;
            logic [7:0] rs, rd, rn, rf;
            for (int k = 0; k < 6; k++) preload(8'($urandom), 8'($urandom));
            rm = 1'($urandom);
            rs = 8'($urandom);
            rd = ($urandom_range(0, 3) == 0) ? rs + 8'($urandom_range(1, 3)) : 8'($urandom);
            rn = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 40));
            rf = 8'($urandom);
            check_xfer($sformatf("rnd%0d", t), rm, rs, rd, rn, rf, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
